// File: rtl/bloom_cfg_pkg.sv
// Shared definitions for the Bloom-filter configuration loader: op encoding,
// FSM state encoding, legal string-length bounds and a length-check helper.
package bloom_cfg_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_SET   = 2'd1,
        OP_UNSET = 2'd2,
        OP_RSVD  = 2'd3
    } cfg_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHK      = 3'd1,
        ST_WR_WAIT  = 3'd2,
        ST_WR_STB   = 3'd3,
        ST_CLR_STB  = 3'd4,
        ST_CLR_WAIT = 3'd5,
        ST_FIN      = 3'd6
    } cfg_state_e;

    localparam int MIN_S_DEF = 4;
    localparam int MAX_S_DEF = 16;

    function automatic logic len_legal(input logic [4:0] len, input int min_s, input int max_s);
        return (int'(len) >= min_s) && (int'(len) <= max_s);
    endfunction

endpackage

// File: rtl/bloom_cfg_wdog.sv
// Clear-completion watchdog: down-counter reloaded by clr_i, expires when it
// reaches zero while enabled (LIMIT enabled cycles after the last clear).
module bloom_cfg_wdog
    import bloom_cfg_pkg::*;
#(
    parameter int LIMIT = 4096
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= LOAD;
        end else if (clr_i) begin
            cnt_q <= LOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/bloom_cfg_loader.sv
// Bloom-filter configuration loader: accepts CLEAR/SET/UNSET commands and
// sequences them onto the filter. Define BLOOM_CFG_LOADER_TIMEOUT_EN to add a clear watchdog.
//
// state    | meaning
// IDLE     | ready for a command
// CHK      | validate registered command
// WR_WAIT  | hold write fields until filter ready_i
// WR_STB   | one-cycle write strobe
// CLR_STB  | one-cycle full-clear strobe
// CLR_WAIT | wait for full_clr_done_i (optionally watchdog-limited)
// FIN      | done pulse, count completed writes
module bloom_cfg_loader
    import bloom_cfg_pkg::*;
#(
    parameter int HASH_CNT    = 10,
    parameter int HASH_WIDTH  = 12,
    parameter int MIN_S       = MIN_S_DEF,
    parameter int MAX_S       = MAX_S_DEF,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           cmd_val_i,
    output logic                           cmd_ready_o,
    input  logic [1:0]                     cmd_op_i,
    input  logic [4:0]                     cmd_str_len_i,
    input  logic [HASH_CNT*HASH_WIDTH-1:0] cmd_hash_i,
    input  logic [HASH_CNT-1:0]            cmd_hash_mask_i,
    output logic [4:0]                     str_len_o,
    output logic [HASH_CNT*HASH_WIDTH-1:0] hash_o,
    output logic [HASH_CNT-1:0]            hash_mask_val_o,
    output logic                           wr_data_o,
    output logic                           wr_stb_o,
    output logic                           full_clr_stb_o,
    input  logic                           ready_i,
    input  logic                           full_clr_done_i,
    output logic                           done_o,
    output logic                           err_o,
    output logic [15:0]                    wr_cnt_o
);

    localparam logic [2:0] IDLE     = ST_IDLE;
    localparam logic [2:0] CHK      = ST_CHK;
    localparam logic [2:0] WR_WAIT  = ST_WR_WAIT;
    localparam logic [2:0] WR_STB   = ST_WR_STB;
    localparam logic [2:0] CLR_STB  = ST_CLR_STB;
    localparam logic [2:0] CLR_WAIT = ST_CLR_WAIT;
    localparam logic [2:0] FIN      = ST_FIN;

    logic [2:0]                     state_q, state_d;
    logic                           rdy_en_q;
    logic [1:0]                     op_q;
    logic [4:0]                     str_len_q;
    logic [HASH_CNT*HASH_WIDTH-1:0] hash_q;
    logic [HASH_CNT-1:0]            mask_q;
    logic [15:0]                    wr_cnt_q;
    logic                           accept;
    logic                           cmd_illegal;
    logic                           wdog_expired;

    assign accept      = cmd_val_i && cmd_ready_o;
    assign cmd_illegal = (op_q == OP_RSVD) ||
                         ((op_q != OP_CLEAR) && !len_legal(str_len_q, MIN_S, MAX_S));

`ifdef BLOOM_CFG_LOADER_TIMEOUT_EN
    logic wdog_en;
    logic wdog_clr;

    assign wdog_en  = (state_q == CLR_WAIT);
    assign wdog_clr = (state_q != CLR_WAIT);

    bloom_cfg_wdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .en_i      (wdog_en),
        .clr_i     (wdog_clr),
        .expired_o (wdog_expired)
    );
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYC > 0);
    assign wdog_expired   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = CHK;
            CHK: begin
                if (cmd_illegal)            state_d = IDLE;
                else if (op_q == OP_CLEAR)  state_d = CLR_STB;
                else                        state_d = WR_WAIT;
            end
            WR_WAIT:  if (ready_i) state_d = WR_STB;
            WR_STB:   state_d = FIN;
            CLR_STB:  state_d = CLR_WAIT;
            // a done arriving on the expiry cycle still completes the clear
            CLR_WAIT: begin
                if (full_clr_done_i)   state_d = FIN;
                else if (wdog_expired) state_d = IDLE;
            end
            FIN:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_q      <= '0;
            str_len_q <= '0;
            hash_q    <= '0;
            mask_q    <= '0;
        end else if (accept) begin
            op_q      <= cmd_op_i;
            str_len_q <= cmd_str_len_i;
            hash_q    <= cmd_hash_i;
            mask_q    <= cmd_hash_mask_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_cnt_q <= '0;
        end else if ((state_q == FIN) && (op_q != OP_CLEAR) && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end

    // reset holds cmd_ready_o low; it rises on the first edge after release
    assign cmd_ready_o     = (state_q == IDLE) && rdy_en_q;
    assign str_len_o       = str_len_q;
    assign hash_o          = hash_q;
    assign hash_mask_val_o = mask_q;
    assign wr_data_o       = (op_q == OP_SET);
    assign wr_stb_o        = (state_q == WR_STB);
    assign full_clr_stb_o  = (state_q == CLR_STB);
    assign done_o          = (state_q == FIN);
    assign err_o           = ((state_q == CHK) && cmd_illegal) ||
                             ((state_q == CLR_WAIT) && !full_clr_done_i && wdog_expired);
    assign wr_cnt_o        = wr_cnt_q;

endmodule

// File: tb/tb_bloom_cfg_loader.sv
// Self-checking bench for bloom_cfg_loader: an event-schedule model predicts
// strobe/done/err cycles per command, a negedge process compares every cycle.
module tb_bloom_cfg_loader;

    localparam int HC = 10;
    localparam int HW = 12;
    localparam int HV = HC * HW;
    localparam int TO = 16;
`ifdef BLOOM_CFG_LOADER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b1;
    logic          cmd_val_i = 1'b0;
    logic          cmd_ready_o;
    logic [1:0]    cmd_op_i = '0;
    logic [4:0]    cmd_str_len_i = '0;
    logic [HV-1:0] cmd_hash_i = '0;
    logic [HC-1:0] cmd_hash_mask_i = '0;
    logic [4:0]    str_len_o;
    logic [HV-1:0] hash_o;
    logic [HC-1:0] hash_mask_val_o;
    logic          wr_data_o;
    logic          wr_stb_o;
    logic          full_clr_stb_o;
    logic          ready_i = 1'b0;
    logic          full_clr_done_i = 1'b0;
    logic          done_o;
    logic          err_o;
    logic [15:0]   wr_cnt_o;

    bloom_cfg_loader #(
        .HASH_CNT    (HC),
        .HASH_WIDTH  (HW),
        .MIN_S       (4),
        .MAX_S       (16),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .cmd_val_i       (cmd_val_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_op_i        (cmd_op_i),
        .cmd_str_len_i   (cmd_str_len_i),
        .cmd_hash_i      (cmd_hash_i),
        .cmd_hash_mask_i (cmd_hash_mask_i),
        .str_len_o       (str_len_o),
        .hash_o          (hash_o),
        .hash_mask_val_o (hash_mask_val_o),
        .wr_data_o       (wr_data_o),
        .wr_stb_o        (wr_stb_o),
        .full_clr_stb_o  (full_clr_stb_o),
        .ready_i         (ready_i),
        .full_clr_done_i (full_clr_done_i),
        .done_o          (done_o),
        .err_o           (err_o),
        .wr_cnt_o        (wr_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    // model: expected event cycles and busy/data windows
    bit ev_stb[int];
    bit ev_clr[int];
    bit ev_done[int];
    bit ev_err[int];
    bit ev_cnt[int];
    int busy_lo = -1, busy_hi = -1, ready_ok = 1 << 30;
    int exp_cnt = 0;
    int win_lo = -1, win_hi = -1;
    logic [4:0]    win_len;
    logic [HV-1:0] win_hash;
    logic [HC-1:0] win_mask;
    logic          win_data;

    int stb_seen = 0, clr_seen = 0, err_seen = 0, done_seen = 0;
    int last_stb = -1, last_err = -1, last_done = -1;
    logic          stb_data;
    logic [HW-1:0] stb_hash0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            chk("rst_ready", cmd_ready_o, 0);
            chk("rst_wr_stb", wr_stb_o, 0);
            chk("rst_clr_stb", full_clr_stb_o, 0);
            chk("rst_done", done_o, 0);
            chk("rst_err", err_o, 0);
            chk("rst_wr_cnt", wr_cnt_o, 0);
            chk("rst_str_len", str_len_o, 0);
            chk("rst_hash", hash_o, 0);
        end else begin
            if (ev_cnt.exists(cyc) && exp_cnt < 65535) exp_cnt++;
            chk("cmd_ready", cmd_ready_o, (cyc >= ready_ok) && !((cyc >= busy_lo) && (cyc <= busy_hi)));
            chk("wr_stb", wr_stb_o, ev_stb.exists(cyc));
            chk("full_clr_stb", full_clr_stb_o, ev_clr.exists(cyc));
            chk("done", done_o, ev_done.exists(cyc));
            chk("err", err_o, ev_err.exists(cyc));
            chk("wr_cnt", wr_cnt_o, exp_cnt);
            if ((cyc >= win_lo) && (cyc <= win_hi)) begin
                chk("str_len_stable", str_len_o, win_len);
                chk("hash_stable", hash_o, win_hash);
                chk("mask_stable", hash_mask_val_o, win_mask);
                chk("wr_data_stable", wr_data_o, win_data);
            end
        end
        if (wr_stb_o) begin
            stb_seen++; last_stb = cyc; stb_data = wr_data_o; stb_hash0 = hash_o[HW-1:0];
        end
        if (full_clr_stb_o) clr_seen++;
        if (err_o) begin err_seen++; last_err = cyc; end
        if (done_o) begin done_seen++; last_done = cyc; end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // issue one command; rdy_at/done_at are offsets from accept at which the
    // filter handshake input rises (the other input is held high to be ignored)
    task automatic run_cmd(input logic [1:0] op, input logic [4:0] len, input logic [HW-1:0] h0,
                           input logic [HC-1:0] mask, input int rdy_at, input int done_at,
                           output int a);
        int e, r, d;
        bit legal;
        logic [HV-1:0] hv = '0;
        for (int i = 0; i < HC; i++) hv[i*HW +: HW] = h0 + HW'(i * 'h111);
        while (cyc <= busy_hi) step();
        a = cyc;
        legal = (op != 2'd3) && ((op == 2'd0) || ((len >= 5'd4) && (len <= 5'd16)));
        busy_lo = a + 1;
        if (!legal) begin
            e = a + 1;
            ev_err[e] = 1'b1;
        end else if (op == 2'd0) begin
            ev_clr[a + 2] = 1'b1;
            d = a + ((done_at > 3) ? done_at : 3);
            if (TO_EN && (d - (a + 3) >= TO)) begin
                e = a + 3 + TO - 1;
                ev_err[e] = 1'b1;
            end else begin
                e = d + 1;
                ev_done[e] = 1'b1;
            end
        end else begin
            r = a + ((rdy_at > 2) ? rdy_at : 2);
            ev_stb[r + 1] = 1'b1;
            ev_done[r + 2] = 1'b1;
            ev_cnt[r + 3] = 1'b1;
            e = r + 2;
            win_lo = a + 2; win_hi = e;
            win_len = len; win_hash = hv; win_mask = mask; win_data = (op == 2'd1);
        end
        busy_hi = e;
        cmd_val_i = 1'b1; cmd_op_i = op; cmd_str_len_i = len;
        cmd_hash_i = hv; cmd_hash_mask_i = mask;
        for (int k = 0; a + k <= e; k++) begin
            if (k == 1) cmd_val_i = 1'b0;
            if (op == 2'd0) begin
                ready_i = 1'b1; full_clr_done_i = (k >= done_at);
            end else begin
                full_clr_done_i = 1'b1; ready_i = (k >= rdy_at);
            end
            step();
        end
        cmd_val_i = 1'b0; ready_i = 1'b0; full_clr_done_i = 1'b0;
    endtask

    initial begin
        int a, s0, e0, c0;
        #1 rst_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1; ready_ok = cyc + 1; exp_cnt = 0;
        step();
        chk("ready_after_release", cmd_ready_o, 1);

        // SET len 8, ready already high: strobe three cycles after accept
        run_cmd(2'd1, 5'd8, 12'h123, 10'h3FF, 0, 0, a);
        chk("set_latency", last_stb - a, 3);
        chk("set_data", stb_data, 1);
        chk("set_hash0", stb_hash0, 12'h123);
        chk("set_done_after_stb", last_done - last_stb, 1);
        chk("set_cnt", wr_cnt_o, 1);

        // UNSET, ready held low ~20 cycles inside WR_WAIT
        run_cmd(2'd2, 5'd12, 12'hABC, 10'h155, 22, 0, a);
        chk("unset_latency", last_stb - a, 23);
        chk("unset_data", stb_data, 0);
        chk("unset_cnt", wr_cnt_o, 2);

        // illegal lengths and reserved op
        s0 = stb_seen; e0 = err_seen;
        run_cmd(2'd1, 5'd3, 12'h001, 10'h3FF, 0, 0, a);
        chk("len3_err_cycle", last_err - a, 1);
        run_cmd(2'd1, 5'd17, 12'h002, 10'h3FF, 0, 0, a);
        run_cmd(2'd3, 5'd8, 12'h003, 10'h3FF, 0, 0, a);
        chk("illegal_err_count", err_seen - e0, 3);
        chk("illegal_no_stb", stb_seen - s0, 0);
        chk("illegal_cnt", wr_cnt_o, 2);

        // boundary lengths are legal
        run_cmd(2'd2, 5'd4, 12'hFFF, 10'h001, 1, 0, a);
        run_cmd(2'd1, 5'd16, 12'h800, 10'h200, 5, 0, a);
        chk("bound_cnt", wr_cnt_o, 4);

        // CLEAR with done after 50 cycles, len ignored
        c0 = clr_seen; s0 = stb_seen;
        run_cmd(2'd0, 5'd0, 12'h000, 10'h000, 0, 50, a);
        chk("clear_one_strobe", clr_seen - c0, 1);
        chk("clear_no_wr_stb", stb_seen - s0, 0);
        chk("clear_cnt", wr_cnt_o, 4);
`ifdef BLOOM_CFG_LOADER_TIMEOUT_EN
        chk("clear50_timeout_err", last_err - a, 3 + TO - 1);
`else
        chk("clear50_done", last_done - a, 51);
`endif

        // CLEAR with done already high: ignored until CLR_WAIT
        run_cmd(2'd0, 5'd31, 12'h000, 10'h000, 0, 0, a);
        chk("clear_early_done", last_done - a, 4);

`ifdef BLOOM_CFG_LOADER_TIMEOUT_EN
        d_timeout: begin
            int d0;
            d0 = done_seen;
            run_cmd(2'd0, 5'd0, 12'h000, 10'h000, 0, 1000, a);
            chk("timeout_err_cycle", last_err - a, 18);
            chk("timeout_no_done", done_seen - d0, 0);
            chk("timeout_ready", cmd_ready_o, 1);
        end
`endif

        // reset during WR_WAIT abandons the write
        while (cyc <= busy_hi) step();
        a = cyc; s0 = stb_seen;
        busy_lo = a + 1; busy_hi = 1 << 30;
        cmd_val_i = 1'b1; cmd_op_i = 2'd1; cmd_str_len_i = 5'd8;
        ready_i = 1'b0; full_clr_done_i = 1'b0;
        step();
        cmd_val_i = 1'b0;
        repeat (4) step();
        rst_n_i = 1'b0;
        ev_stb.delete(); ev_clr.delete(); ev_done.delete(); ev_err.delete(); ev_cnt.delete();
        busy_hi = -1; ready_ok = 1 << 30; exp_cnt = 0;
        ready_i = 1'b1;
        repeat (2) step();
        rst_n_i = 1'b1; ready_ok = cyc + 1;
        repeat (3) step();
        ready_i = 1'b0;
        chk("rst_no_stb", stb_seen - s0, 0);
        chk("rst_ready_after", cmd_ready_o, 1);
        chk("rst_cnt_zero", wr_cnt_o, 0);

        // recovery write
        run_cmd(2'd1, 5'd9, 12'h5A5, 10'h0F0, 0, 0, a);
        chk("post_rst_latency", last_stb - a, 3);
        chk("post_rst_cnt", wr_cnt_o, 1);

        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach summary");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/bloom_cfg_loader.md
BLOOM_CFG_LOADER -- requirements
Module: bloom_cfg_loader

Interface
REQ-001 SHALL have parameter HASH_CNT, default 10, number of hash functions.
REQ-002 SHALL have parameter HASH_WIDTH, default 12, bit-index width per hash.
REQ-003 SHALL have parameters MIN_S = 4 and MAX_S = 16, legal string-length bounds.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 4096, clear-completion watchdog limit.
REQ-005 SHALL have the following ports (clock and reset first):
- clk_i  in  1  single clock; all logic on its rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- cmd_val_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when cmd_val_i && cmd_ready_o.
- cmd_op_i  in  2  0=CLEAR (full clear), 1=SET (write 1), 2=UNSET (write 0), 3=reserved.
- cmd_str_len_i  in  5  target string length.
- cmd_hash_i  in  HASH_CNT*HASH_WIDTH  packed hash indices.
- cmd_hash_mask_i  in  HASH_CNT  per-hash enable.
- str_len_o  out  5  to filter.
- hash_o  out  HASH_CNT*HASH_WIDTH  to filter.
- hash_mask_val_o  out  HASH_CNT  to filter.
- wr_data_o  out  1  bit value written.
- wr_stb_o  out  1  one-cycle write strobe.
- full_clr_stb_o  out  1  one-cycle full-clear strobe.
- ready_i  in  1  filter ready for a write.
- full_clr_done_i  in  1  filter clear complete.
- done_o  out  1  one-cycle pulse per completed command.
- err_o  out  1  one-cycle pulse per rejected or timed-out command.
- wr_cnt_o  out  16  completed SET/UNSET count, saturating at 0xFFFF.

Function
REQ-006 SHALL implement FSM IDLE, CHK, WR_WAIT, WR_STB, CLR_STB, CLR_WAIT, FIN.
REQ-007 SHALL drive cmd_ready_o = 1 only in IDLE; on accept, register all cmd fields and go to CHK.
REQ-008 CHK SHALL reject when cmd_op=3, or when op is SET/UNSET and str_len < MIN_S or > MAX_S: err_o pulse, return to IDLE, no strobe.
REQ-009 For a legal SET/UNSET, CHK SHALL go to WR_WAIT; WR_WAIT SHALL hold until ready_i = 1, then go to WR_STB.
REQ-010 WR_STB SHALL assert wr_stb_o for exactly one cycle; str_len_o, hash_o, hash_mask_val_o and wr_data_o SHALL be stable from entry to WR_WAIT until return to IDLE.
REQ-011 wr_data_o SHALL be 1 for SET and 0 for UNSET.
REQ-012 For CLEAR, CHK SHALL go to CLR_STB (one-cycle full_clr_stb_o), then CLR_WAIT until full_clr_done_i = 1; str_len is ignored for CLEAR.
REQ-013 FIN SHALL pulse done_o for one cycle and increment wr_cnt_o for SET/UNSET only, saturating; FIN returns to IDLE.
REQ-014 Command acceptance to first strobe SHALL take 3 cycles when ready_i is already high (accept, CHK, WR_WAIT, strobe).
REQ-015 full_clr_done_i or ready_i changes outside the waiting states SHALL be ignored.
REQ-016 done_o and err_o SHALL never be asserted in the same cycle.

Reset
REQ-017 On rst_n_i = 0, state SHALL go to IDLE immediately; all strobes, done_o, err_o, wr_cnt_o and registered fields SHALL clear to 0; cmd_ready_o SHALL be 0 while reset is asserted and 1 one cycle after release.
REQ-018 Reset mid-command SHALL abandon it without issuing a pending strobe.

Configuration
REQ-019 With BLOOM_CFG_LOADER_TIMEOUT_EN defined, CLR_WAIT SHALL count cycles; at TIMEOUT_CYC without full_clr_done_i it SHALL pulse err_o (no done_o) and return to IDLE.
REQ-020 Without BLOOM_CFG_LOADER_TIMEOUT_EN, CLR_WAIT SHALL wait indefinitely and no counter SHALL be instantiated.

Structure
REQ-021 A shared package bloom_cfg_pkg SHALL hold the op encoding enum, FSM state enum, and MIN_S/MAX_S defaults.
REQ-022 The watchdog SHALL be the sub-module bloom_cfg_wdog (count enable, clear, expired), instantiated only under the macro.

Verification
REQ-023 Reset, then SET str_len=8, hash[0]=0x123, mask=0x3FF, ready_i=1 -> wr_stb_o at accept+3, wr_data_o=1, hash_o[0]=0x123, done_o one cycle later, wr_cnt_o=1.
REQ-024 UNSET with ready_i=0 for 20 cycles -> no wr_stb_o until ready_i rises; outputs stable throughout; wr_data_o=0.
REQ-025 SET str_len=3 and SET str_len=17 -> err_o pulse each, no wr_stb_o, wr_cnt_o unchanged.
REQ-026 CLEAR, full_clr_done_i after 50 cycles -> single full_clr_stb_o, done_o after done_i, wr_cnt_o unchanged.
REQ-027 With macro and TIMEOUT_CYC=16, CLEAR with full_clr_done_i held 0 -> err_o at 16 cycles, back to IDLE, cmd_ready_o=1.
REQ-028 rst_n_i low during WR_WAIT -> no wr_stb_o; after release cmd_ready_o=1, wr_cnt_o=0.
